// File: rtl/overcurrent_guard_pkg.sv
// Shared state encodings and H-bridge direction codes for the overcurrent guard.
package overcurrent_guard_pkg;

  typedef enum logic [2:0] {
    ST_ARM    = 3'd0,
    ST_RUN    = 3'd1,
    ST_FILTER = 3'd2,
    ST_TRIP   = 3'd3,
    ST_COOL   = 3'd4,
    ST_LOCK   = 3'd5
  } oc_state_e;

  localparam logic [1:0] DIR_COAST   = 2'b00;
  localparam logic [1:0] DIR_FWD     = 2'b01;
  localparam logic [1:0] DIR_REV     = 2'b10;
  localparam logic [1:0] DIR_ILLEGAL = 2'b11;

  function automatic logic dir_legal(input logic [1:0] cmd);
    return (cmd == DIR_FWD) || (cmd == DIR_REV) || (cmd == DIR_COAST);
  endfunction

endpackage

// File: rtl/overcurrent_guard_oc_channel.sv
// One motor channel: comparator synchronisers, protection FSM with debounce,
// qualified cooldown, bounded auto-retry and latched lockout, plus output gating.
module oc_channel
  import overcurrent_guard_pkg::*;
#(
  parameter int DEBOUNCE  = 4,
  parameter int COOLDOWN  = 8,
  parameter int MAX_RETRY = 2,
  parameter int RW        = $clog2(MAX_RETRY + 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pwm_in,
  input  logic [1:0]    motor_cmd,
  input  logic          over,
  input  logic          under,
  input  logic          clear,
  output logic          en_out,
  output logic [1:0]    motor_out,
  output logic          fault,
  output logic          lockout,
  output logic [RW-1:0] trip_count
);

  localparam int TW = $clog2(COOLDOWN + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [RW-1:0] TRIP_MAX  = RW'(MAX_RETRY + 1);
  localparam logic [TW-1:0] TIMER_END = TW'(COOLDOWN - 1);
  localparam logic [DW-1:0] DEB_END   = DW'(DEBOUNCE - 1);

  function automatic logic [RW-1:0] sat_inc(input logic [RW-1:0] v);
    return (v >= TRIP_MAX) ? TRIP_MAX : v + 1'b1;
  endfunction

  logic          over_meta_q, over_s_q, under_meta_q, under_s_q;
  oc_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] trip_q, trip_d;
  logic          qual, ok;
  logic [RW-1:0] trip_base;

  // Both comparators high is inconsistent; it must never count as a safe cycle.
  assign qual      = under_s_q & ~over_s_q;
  assign trip_base = clear ? '0 : trip_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    trip_d  = trip_q;
    unique case (state_q)
      ST_ARM, ST_COOL: begin
        trip_d = trip_base;
        if (!qual) begin
          timer_d = '0;
        end else if (timer_q == TIMER_END) begin
          state_d = ST_RUN;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RUN: begin
        trip_d = trip_base;
        if (over_s_q) begin
          if (DEBOUNCE == 1) begin
            state_d = ST_TRIP;
            trip_d  = sat_inc(trip_base);
          end else begin
            state_d = ST_FILTER;
            cnt_d   = DW'(1);
          end
        end
      end
      ST_FILTER: begin
        trip_d = trip_base;
        if (!over_s_q) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == DEB_END) begin
          state_d = ST_TRIP;
          cnt_d   = '0;
          trip_d  = sat_inc(trip_base);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_TRIP: begin
        if (trip_q >= TRIP_MAX) begin
          state_d = ST_LOCK;
        end else begin
          state_d = ST_COOL;
          timer_d = '0;
        end
      end
      ST_LOCK: begin
        // Software clear only releases the bridge once current is genuinely low.
        if (clear && qual) begin
          state_d = ST_RUN;
          trip_d  = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_ARM;
        timer_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      over_meta_q  <= 1'b0;
      over_s_q     <= 1'b0;
      under_meta_q <= 1'b0;
      under_s_q    <= 1'b0;
      state_q      <= ST_ARM;
      timer_q      <= '0;
      cnt_q        <= '0;
      trip_q       <= '0;
    end else begin
      over_meta_q  <= over;
      over_s_q     <= over_meta_q;
      under_meta_q <= under;
      under_s_q    <= under_meta_q;
      state_q      <= state_d;
      timer_q      <= timer_d;
      cnt_q        <= cnt_d;
      trip_q       <= trip_d;
    end
  end

  // Outputs decode registered state only, so PWM passes with zero latency.
  assign ok         = (state_q == ST_RUN) || (state_q == ST_FILTER);
  assign en_out     = pwm_in & ok;
  assign motor_out  = (ok && dir_legal(motor_cmd)) ? motor_cmd : DIR_COAST;
  assign fault      = (state_q == ST_TRIP) || (state_q == ST_COOL) || (state_q == ST_LOCK);
  assign lockout    = (state_q == ST_LOCK);
  assign trip_count = trip_q;

endmodule

// File: rtl/overcurrent_guard.sv
// Multi-channel overcurrent guard: CH independent protection channels between
// the PWM/direction logic and the H-bridge drivers.
module overcurrent_guard
  import overcurrent_guard_pkg::*;
#(
  parameter  int CH        = 2,
  parameter  int DEBOUNCE  = 4,
  parameter  int COOLDOWN  = 8,
  parameter  int MAX_RETRY = 2,
  localparam int RW        = $clog2(MAX_RETRY + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  input  logic [2*CH-1:0]   motor_cmd,
  input  logic [CH-1:0]     over,
  input  logic [CH-1:0]     under,
  input  logic [CH-1:0]     clear,
  output logic [CH-1:0]     en_out,
  output logic [2*CH-1:0]   motor_out,
  output logic [CH-1:0]     fault,
  output logic [CH-1:0]     lockout,
  output logic [CH*RW-1:0]  trip_count
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    oc_channel #(
      .DEBOUNCE  (DEBOUNCE),
      .COOLDOWN  (COOLDOWN),
      .MAX_RETRY (MAX_RETRY),
      .RW        (RW)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .pwm_in     (pwm_in),
      .motor_cmd  (motor_cmd[2*i +: 2]),
      .over       (over[i]),
      .under      (under[i]),
      .clear      (clear[i]),
      .en_out     (en_out[i]),
      .motor_out  (motor_out[2*i +: 2]),
      .fault      (fault[i]),
      .lockout    (lockout[i]),
      .trip_count (trip_count[RW*i +: RW])
    );
  end

endmodule

// File: tb/tb_overcurrent_guard.sv
// Scoreboard bench for overcurrent_guard: the driver pushes model predictions,
// an independent monitor pops and compares after every rising edge.
module tb_overcurrent_guard;
  localparam int CH        = 2;
  localparam int DEBOUNCE  = 4;
  localparam int COOLDOWN  = 8;
  localparam int MAX_RETRY = 2;
  localparam int RW        = $clog2(MAX_RETRY + 2);

  localparam int HOLD = 0, RUNNING = 1, TRIPPED = 2, COOLING = 3, LOCKED = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pwm_in = 1'b0;
  logic [2*CH-1:0]   motor_cmd = '0;
  logic [CH-1:0]     over = '0, under = '0, clear = '0;
  logic [CH-1:0]     en_out, fault, lockout;
  logic [2*CH-1:0]   motor_out;
  logic [CH*RW-1:0]  trip_count;

  overcurrent_guard #(
    .CH(CH), .DEBOUNCE(DEBOUNCE), .COOLDOWN(COOLDOWN), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .motor_cmd(motor_cmd),
    .over(over), .under(under), .clear(clear), .en_out(en_out),
    .motor_out(motor_out), .fault(fault), .lockout(lockout), .trip_count(trip_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0]    en;
    logic [2*CH-1:0]  mo;
    logic [CH-1:0]    f;
    logic [CH-1:0]    lk;
    logic [CH*RW-1:0] tc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  logic            k_rst = 1'b0;
  logic [2*CH-1:0] k_cmd = '0;
  logic [CH-1:0]   k_over = '0, k_under = '0, k_clear = '0;

  // Reference model: per-channel mode plus streak counters of synchronised samples.
  int m_mode[CH], m_streak[CH], m_qual[CH], m_trips[CH];
  bit m_ovm[CH], m_ovs[CH], m_unm[CH], m_uns[CH];

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      m_mode[i] = HOLD; m_streak[i] = 0; m_qual[i] = 0; m_trips[i] = 0;
      m_ovm[i] = 0; m_ovs[i] = 0; m_unm[i] = 0; m_uns[i] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int i = 0; i < CH; i++) begin
      bit safe = m_uns[i] && !m_ovs[i];
      case (m_mode[i])
        HOLD, COOLING: begin
          if (clear[i]) m_trips[i] = 0;
          if (safe) begin
            m_qual[i]++;
            if (m_qual[i] == COOLDOWN) begin m_mode[i] = RUNNING; m_qual[i] = 0; m_streak[i] = 0; end
          end else m_qual[i] = 0;
        end
        RUNNING: begin
          if (clear[i]) m_trips[i] = 0;
          if (m_ovs[i]) begin
            m_streak[i]++;
            if (m_streak[i] == DEBOUNCE) begin
              m_mode[i] = TRIPPED; m_streak[i] = 0;
              m_trips[i] = (m_trips[i] + 1 > MAX_RETRY + 1) ? MAX_RETRY + 1 : m_trips[i] + 1;
            end
          end else m_streak[i] = 0;
        end
        TRIPPED: begin
          m_mode[i] = (m_trips[i] > MAX_RETRY) ? LOCKED : COOLING;
          m_qual[i] = 0;
        end
        LOCKED: if (clear[i] && safe) begin m_mode[i] = RUNNING; m_trips[i] = 0; m_streak[i] = 0; end
        default: m_mode[i] = HOLD;
      endcase
      m_ovs[i] = m_ovm[i]; m_ovm[i] = over[i];
      m_uns[i] = m_unm[i]; m_unm[i] = under[i];
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    for (int i = 0; i < CH; i++) begin
      logic [1:0] c;
      c = motor_cmd[2*i +: 2];
      e.en[i] = pwm_in && (m_mode[i] == RUNNING);
      e.mo[2*i +: 2] = (m_mode[i] == RUNNING && c != 2'b11) ? c : 2'b00;
      e.f[i]  = (m_mode[i] == TRIPPED) || (m_mode[i] == COOLING) || (m_mode[i] == LOCKED);
      e.lk[i] = (m_mode[i] == LOCKED);
      e.tc[RW*i +: RW] = RW'(m_trips[i]);
    end
    return e;
  endfunction

  task automatic step();
    @(negedge clk);
    pwm_in = ((cyc % 10) < 5);
    cyc++;
    rst_n = k_rst; motor_cmd = k_cmd; over = k_over; under = k_under; clear = k_clear;
    if (!k_rst) model_reset(); else model_step();
    exp_q.push_back(model_out());
  endtask

  task automatic steps(input int n);
    for (int s = 0; s < n; s++) step();
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  exp_t mon_exp, mon_got;
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = {en_out, motor_out, fault, lockout, trip_count};
      total++;
      if (mon_got !== mon_exp) begin
        bad++;
        $display("FAIL scoreboard cyc=%0d: got en=%b mo=%b f=%b lk=%b tc=%b required en=%b mo=%b f=%b lk=%b tc=%b",
                 cyc, mon_got.en, mon_got.mo, mon_got.f, mon_got.lk, mon_got.tc,
                 mon_exp.en, mon_exp.mo, mon_exp.f, mon_exp.lk, mon_exp.tc);
      end
    end
  end

  int prof[CH];

  initial begin
    model_reset();
    k_rst = 1'b0;
    steps(3);
    after_edge();
    chk("reset_outputs", {en_out, motor_out, fault, lockout}, 8'h00);
    chk("reset_trip", 8'(trip_count), 8'h00);

    // Startup hold: RUN reached exactly on edge 10 after release.
    k_rst = 1'b1; k_under = 2'b11; k_over = 2'b00; k_cmd = 4'b0101;
    steps(9);
    after_edge();
    chk("arm_edge9_motor", 8'(motor_out), 8'h00);
    chk("arm_edge9_fault", 8'(fault), 8'h00);
    step();
    after_edge();
    chk("run_edge10_motor", 8'(motor_out), 8'h05);
    steps(10);

    // Short glitch is rejected.
    k_over = 2'b01; steps(3);
    k_over = 2'b00; steps(6);
    after_edge();
    chk("glitch_trip", 8'(trip_count), 8'h00);
    chk("glitch_fault", 8'(fault), 8'h00);

    // Sustained over-current trips on the sixth edge.
    k_over = 2'b01; k_under = 2'b10;
    steps(5);
    after_edge();
    chk("trip_edge5_motor0", 8'(motor_out[1:0]), 8'h01);
    step();
    after_edge();
    chk("trip_edge6_motor0", 8'(motor_out[1:0]), 8'h00);
    chk("trip_edge6_fault", 8'(fault), 8'h01);
    chk("trip_edge6_count0", 8'(trip_count[RW-1:0]), 8'h01);
    chk("trip_ch1_motor", 8'(motor_out[3:2]), 8'h01);
    steps(2);

    // Cooldown with one interrupted qualified cycle.
    k_over = 2'b00; k_under = 2'b11; steps(6);
    k_under = 2'b10; step();
    k_under = 2'b11; steps(20);
    after_edge();
    chk("cool_done_fault", 8'(fault), 8'h00);

    // Second and third trip without clear: lockout.
    k_over = 2'b01; k_under = 2'b10; steps(8);
    k_over = 2'b00; k_under = 2'b11; steps(25);
    k_over = 2'b01; k_under = 2'b10; steps(8);
    after_edge();
    chk("lock_flag", 8'(lockout), 8'h01);
    chk("lock_count0", 8'(trip_count[RW-1:0]), 8'h03);
    k_over = 2'b00; k_under = 2'b11; steps(100);
    after_edge();
    chk("lock_held", 8'(lockout), 8'h01);
    k_under = 2'b10; steps(3);
    k_clear = 2'b01; step();
    k_clear = 2'b00; steps(1);
    after_edge();
    chk("lock_clear_ignored", 8'(lockout), 8'h01);
    k_under = 2'b11; steps(3);
    k_clear = 2'b01; step();
    after_edge();
    chk("lock_released", 8'(lockout), 8'h00);
    chk("lock_released_count", 8'(trip_count[RW-1:0]), 8'h00);
    k_clear = 2'b00;

    // Illegal direction is coasted but PWM still passes.
    k_cmd = 4'b1101; steps(5);
    after_edge();
    chk("illegal_motor", 8'(motor_out), 8'h01);
    chk("illegal_en1", 8'(en_out[1]), 8'(pwm_in));

    // Asynchronous reset while cooling.
    k_cmd = 4'b0101; k_over = 2'b01; k_under = 2'b10; steps(8);
    k_over = 2'b00; k_under = 2'b11; steps(3);
    after_edge();
    chk("cool_before_reset", 8'(fault), 8'h01);
    k_rst = 1'b0; step();
    #1;
    chk("async_rst_fault", 8'(fault), 8'h00);
    chk("async_rst_en", 8'(en_out), 8'h00);
    chk("async_rst_count", 8'(trip_count), 8'h00);
    steps(2);
    k_rst = 1'b1; steps(12);

    // Randomised profiles per channel.
    for (int s = 0; s < 3000; s++) begin
      if (s % 30 == 0) for (int i = 0; i < CH; i++) prof[i] = $urandom_range(0, 3);
      if (s % 7 == 0) k_cmd = 4'($urandom);
      for (int i = 0; i < CH; i++) begin
        case (prof[i])
          0: begin k_over[i] = ($urandom_range(0, 99) < 3);  k_under[i] = ($urandom_range(0, 99) >= 5); end
          1: begin k_over[i] = ($urandom_range(0, 99) < 30); k_under[i] = ($urandom_range(0, 99) >= 10); end
          2: begin k_over[i] = 1'b1; k_under[i] = 1'b0; end
          default: begin k_over[i] = ($urandom_range(0, 99) < 50); k_under[i] = 1'($urandom); end
        endcase
        k_clear[i] = ($urandom_range(0, 99) < 3);
      end
      k_rst = ($urandom_range(0, 999) != 0);
      step();
    end

    after_edge();
    after_edge();
    chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
